// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator.
// One instruction per cycle in over valid/ready. The decoded immediate,
// format code, illegal flag and tag appear one cycle later. An output
// register plus a skid register keep full throughput under backpressure
// while in_ready stays a registered signal.
//
// state       | meaning
// ------------+--------------------------------------------------
// empty       | out_valid=0, skid_full=0: nothing held
// out only    | out_valid=1, skid_full=0: result waiting, input open
// out + skid  | out_valid=1, skid_full=1: both slots full, in_ready=0
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] dec_count
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic             skid_full;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    logic             in_xfer;
    logic             out_xfer;
    logic             out_free;

    assign in_ready = !skid_full;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    // Output register can take new data when empty or draining this cycle.
    assign out_free = !out_valid || out_ready;

    // Decode the incoming instruction into a 32-bit immediate, then widen.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_fmt = FMT_I;
                end
                7'b0100011: begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    dec_fmt = FMT_S;
                end
                7'b1100011: begin
                    imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                    dec_fmt = FMT_B;
                end
                7'b0110111, 7'b0010111: begin
                    imm32   = {in_instr[31:12], 12'b0};
                    dec_fmt = FMT_U;
                end
                7'b1101111: begin
                    imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
                    dec_fmt = FMT_J;
                end
                7'b0110011, 7'b0001111: begin
                    dec_fmt = FMT_NONE;
                end
                default: begin
                    dec_ill = 1'b1;
                end
            endcase
        end
        // Bit 31 of every format is the sign, so replicate it across XLEN.
        dec_imm       = {XLEN{imm32[31]}};
        dec_imm[31:0] = imm32;
    end

    // Occupancy of the output and skid slots; flush empties both.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                out_valid <= in_xfer;
            end
        end else if (in_xfer) begin
            skid_full <= 1'b1;
        end
    end

    // Output payload: older skid entry first, otherwise the fresh decode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (!flush && out_free) begin
            if (skid_full) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_ill;
                out_tag     <= skid_tag;
            end else if (in_xfer) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end
        end
    end

    // Skid payload captures an accepted input while the output is stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skid_imm <= '0;
            skid_fmt <= '0;
            skid_ill <= 1'b0;
            skid_tag <= '0;
        end else if (!flush && !out_free && in_xfer) begin
            skid_imm <= dec_imm;
            skid_fmt <= dec_fmt;
            skid_ill <= dec_ill;
            skid_tag <= in_tag;
        end
    end

    // Retired-decode counter; output handshakes count even during flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dec_count <= '0;
        end else if (out_xfer) begin
            dec_count <= dec_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe with an expected-result queue.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_tag;
    logic [15:0] dec_count;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;
    logic [31:0] out_tag64;
    logic [15:0] dec_count64;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   n_out     = 0;
    int   cyc       = 0;
    bit   lat1      = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_tag    (out_tag),
        .dec_count  (dec_count)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u_dut64 (
        .clk        (clk),
        .n_rst      (n_rst),
        .flush      (1'b0),
        .in_valid   (in_valid64),
        .in_ready   (in_ready64),
        .in_instr   (in_instr64),
        .in_tag     (32'h0),
        .out_valid  (out_valid64),
        .out_ready  (1'b1),
        .out_imm    (out_imm64),
        .out_fmt    (out_fmt64),
        .out_illegal(out_illegal64),
        .out_tag    (out_tag64),
        .dec_count  (dec_count64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus (called at posedge+1) and queue the expected result.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic [31:0] eimm, input logic [2:0] efmt,
                        input logic eill);
        exp_t e;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = ordy;
        if (v && in_ready && !flush && n_rst) begin
            e.imm = eimm; e.fmt = efmt; e.ill = eill; e.tag = tg; e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // Mid-cycle monitor: every output handshake must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (n_rst && out_valid && out_ready) begin
            chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_out++;
                chk("imm", 64'(out_imm), 64'(e.imm));
                chk("fmt", 64'(out_fmt), 64'(e.fmt));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
                chk("tag", 64'(out_tag), 64'(e.tag));
                if (lat1) chk("latency", 64'(cyc - e.cyc), 64'd1);
            end
        end
    end

    initial begin
        n_rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
        out_ready = 1'b0; in_valid64 = 1'b0; in_instr64 = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_dec_count", 64'(dec_count), 64'd0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back stream of all five formats.
        lat1 = 1'b1;
        step(1, 32'hFFF00093, 32'h00, 1, 32'hFFFFFFFF, 3'd1, 0);
        step(1, 32'hFE112E23, 32'h04, 1, 32'hFFFFFFFC, 3'd2, 0);
        step(1, 32'hFE000CE3, 32'h08, 1, 32'hFFFFFFF8, 3'd3, 0);
        step(1, 32'h123452B7, 32'h0C, 1, 32'h12345000, 3'd4, 0);
        step(1, 32'h001000EF, 32'h10, 1, 32'h00000800, 3'd5, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        lat1 = 1'b0;
        chk("stream_count", 64'(dec_count), 64'd5);

        // Backpressure: two accepted, third refused until the skid drains.
        step(1, 32'h00500093, 32'h100, 0, 32'h00000005, 3'd1, 0);
        step(1, 32'hFFF00093, 32'h104, 0, 32'hFFFFFFFF, 3'd1, 0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        step(1, 32'h123452B7, 32'h108, 0, 32'h12345000, 3'd4, 0);
        step(1, 32'h123452B7, 32'h108, 0, 32'h12345000, 3'd4, 0);
        chk("bp_stall_tag", 64'(out_tag), 64'h100);
        chk("bp_stall_imm", 64'(out_imm), 64'h5);
        step(1, 32'h123452B7, 32'h108, 1, 32'h12345000, 3'd4, 0);
        step(1, 32'h123452B7, 32'h108, 1, 32'h12345000, 3'd4, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        chk("bp_count", 64'(dec_count), 64'd8);

        // Illegal opcode and low-bit checks.
        step(1, 32'h0000007F, 32'h200, 1, 32'h0, 3'd0, 1);
        step(1, 32'h00000093, 32'h204, 1, 32'h0, 3'd1, 0);
        step(1, 32'h00000091, 32'h208, 1, 32'h0, 3'd0, 1);
        step(1, 32'h00000033, 32'h20C, 1, 32'h0, 3'd0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);

        // Flush with both slots full; the input offered alongside is dropped.
        step(1, 32'hFFF00093, 32'h300, 0, 32'hFFFFFFFF, 3'd1, 0);
        step(1, 32'hFE112E23, 32'h304, 0, 32'hFFFFFFFC, 3'd2, 0);
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        step(1, 32'h001000EF, 32'h308, 0, 32'h00000800, 3'd5, 0);
        flush = 1'b0;
        exp_q.delete();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_count", 64'(dec_count), 64'(n_out));

        // Flush cycle that also completes an output handshake.
        step(1, 32'h00500093, 32'h310, 0, 32'h00000005, 3'd1, 0);
        flush = 1'b1;
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        flush = 1'b0;
        exp_q.delete();
        chk("fl_hs_out_valid", 64'(out_valid), 64'd0);
        chk("fl_hs_count", 64'(dec_count), 64'(n_out));

        // Asynchronous reset in the middle of a stalled stream.
        step(1, 32'hFFF00093, 32'h400, 0, 32'hFFFFFFFF, 3'd1, 0);
        step(1, 32'hFE112E23, 32'h404, 0, 32'hFFFFFFFC, 3'd2, 0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_out_imm", 64'(out_imm), 64'd0);
        chk("ar_out_fmt", 64'(out_fmt), 64'd0);
        chk("ar_out_tag", 64'(out_tag), 64'd0);
        chk("ar_dec_count", 64'(dec_count), 64'd0);
        exp_q.delete();
        n_out = 0;
        in_valid = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        lat1 = 1'b1;
        step(1, 32'h123452B7, 32'h500, 1, 32'h12345000, 3'd4, 0);
        step(0, 32'h0, 32'h0, 1, 32'h0, 3'd0, 0);
        lat1 = 1'b0;
        chk("ar_count", 64'(dec_count), 64'd1);

        // 64-bit instance: sign extension past bit 31.
        in_instr64 = 32'hFFF00093; in_valid64 = 1'b1;
        @(posedge clk); #1;
        chk("x64_valid", 64'(out_valid64), 64'd1);
        chk("x64_imm_i", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        in_instr64 = 32'h800002B7;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        chk("x64_imm_u", out_imm64, 64'hFFFF_FFFF_8000_0000);
        chk("x64_fmt_u", 64'(out_fmt64), 64'd4);
        @(posedge clk); #1;
        chk("x64_count", 64'(dec_count64), 64'd2);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Accepts one RV32I instruction per cycle over a valid/ready handshake, decodes all immediate formats (I, S, B, U, J), and sign-extends to XLEN. It delivers the result plus a format code, an illegal flag and a passthrough tag one cycle later. Sits between fetch and the ID/EX register. A two-entry buffer (output register plus skid register) sustains full throughput under backpressure.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 32, width of the passthrough tag (normally the PC).
CNT_W, 16, width of the retired-decode counter.

Ports:
clk  in  1  clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  instruction valid.
in_ready  out  1  block can accept an instruction.
in_instr  in  32  instruction word.
in_tag  in  TAG_W  tag carried with the instruction.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
out_illegal  out  1  opcode not recognised.
out_tag  out  TAG_W  tag of the result.
dec_count  out  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (n_rst low, asynchronous): out_valid=0, skid empty, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, dec_count=0. in_ready=1 from the first cycle after release.
- Decode (combinational on the input side, registered on capture):
  - I format: opcodes 0000011, 0010011, 1100111, 1110011. Immediate = sext(instr[31:20]). Shift-immediates are not special-cased.
  - S format: opcode 0100011. Immediate = sext({instr[31:25], instr[11:7]}).
  - B format: opcode 1100011. Immediate = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U format: opcodes 0110111, 0010111. Immediate = sext({instr[31:12], 12'b0}). Sign-extends past bit 31 when XLEN=64.
  - J format: opcode 1101111. Immediate = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R/none: opcodes 0110011 and 0001111. imm=0, fmt=0, illegal=0.
  - Illegal: any other opcode, or instr[1:0]!=2'b11. imm=0, fmt=0, illegal=1.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is exactly 1 cycle when the output is free.
  - in_ready = !skid_full. It is registered state, not a combinational path from out_ready.
- Buffering:
  - Transfer while the output register is empty or draining: capture into the output register.
  - Transfer while the output register is held (out_valid && !out_ready): capture into the skid register; skid_full=1.
  - On output transfer with skid_full: skid moves to the output register and skid_full clears.
  - Order is strictly FIFO.
  - Output payload is stable while out_valid && !out_ready.
- Flush (priority over all transfers):
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input presented in the flush cycle is dropped.
  - An output handshake in the flush cycle still counts.
- dec_count: +1 per output transfer. Wraps modulo 2^CNT_W. Not cleared by flush.
- Simultaneous input and output transfer while skid is empty: throughput 1 per cycle, skid stays empty.

Test Plan:
- XLEN=32, stream 0xFFF00093, 0xFE112E23, 0xFE000CE3, 0x123452B7, 0x001000EF back-to-back with out_ready=1. Required output one cycle later each, in order:
  - imm 0xFFFFFFFF, fmt 1
  - imm 0xFFFFFFFC, fmt 2
  - imm 0xFFFFFFF8, fmt 3
  - imm 0x12345000, fmt 4
  - imm 0x00000800, fmt 5
  - dec_count=5 afterwards.
- Backpressure: out_ready=0, present three instructions with tags 0x100/0x104/0x108. Required: first two accepted, in_ready=0 on the third cycle. Release out_ready: tags exit 0x100, 0x104, 0x108; payload stable while stalled.
- Illegal: 0x0000007F and 0x00000093 (bits[1:0]=11, legal) vs 0x00000091 (bits[1:0]=01). Required: 0x7F and 0x91 give illegal=1, imm=0; 0x93 gives illegal=0.
- Flush with output and skid both full: the next cycle has out_valid=0 and in_ready=1, and dec_count is unchanged.
- Assert n_rst low mid-stream, asynchronously between edges: all outputs and dec_count are 0 immediately. First instruction after release emerges with 1-cycle latency.
- XLEN=64: 0xFFF00093 gives 0xFFFFFFFFFFFFFFFF; 0x800002B7 gives 0xFFFFFFFF80000000.
